// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Memory width codes match the data memory group encoding.
package lsu_pkg;

    localparam logic [1:0] DATAWIDTH_BYTE  = 2'b00;
    localparam logic [1:0] DATAWIDTH_SHORT = 2'b01;
    localparam logic [1:0] DATAWIDTH_WORD  = 2'b10;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic [1:0] width;
        logic       uns;
    } load_tag_t;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        logic [2:0] n;
        case (w)
            DATAWIDTH_BYTE:  n = 3'd1;
            DATAWIDTH_SHORT: n = 3'd2;
            default:         n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of the returned load data.
// The memory group already places the addressed byte at [7:0].
module load_extend
    import lsu_pkg::*;
(
    input  logic [1:0]  width_i,
    input  logic        uns_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic sb;
    logic sh;

    always_comb begin
        sb = ~uns_i & rdata_i[7];
        sh = ~uns_i & rdata_i[15];
        result_o = rdata_i;
        case (width_i)
            DATAWIDTH_BYTE:  result_o = {{24{sb}}, rdata_i[7:0]};
            DATAWIDTH_SHORT: result_o = {{16{sh}}, rdata_i[15:0]};
            default:         result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the data memory group: fault check,
// in-flight load tags, writeback extension and load-use hazard.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_DEPTH = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [3:0]          req_rd,
    input  logic                flush,
    input  logic [3:0]          id_rs1,
    input  logic [3:0]          id_rs2,
    output logic                mem_we,
    output logic [1:0]          mem_data_width,
    output logic [2+$clog2(DATA_DEPTH)-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                wb_valid,
    output logic [3:0]          wb_rd,
    output logic [31:0]         wb_data,
    output logic                fault_valid,
    output logic [31:0]         fault_addr,
    output logic                load_use_hazard
);

    localparam int ADDR_W = 2 + $clog2(DATA_DEPTH);
    localparam logic [32:0] MEM_BYTES = 33'(4 * DATA_DEPTH);

    load_tag_t   s1_d, s1_q, s2_d, s2_q;
    logic        fault_d, fault_q;
    logic [31:0] faddr_d, faddr_q;
    logic [32:0] end_addr;
    logic        bad_req;
    logic        accept;
    logic        ld_now;
    logic [31:0] ext_data;

    // End address is computed one bit wider so a top-of-memory
    // wrap shows up as an overflow rather than a small address.
    always_comb begin
        end_addr = {1'b0, req_addr}
                 + {30'd0, width_bytes(req_funct3[1:0])};
        bad_req = (req_funct3[1:0] == 2'b11)
                | (req_we & req_funct3[2])
                | (req_addr[31:ADDR_W] != '0)
                | (end_addr > MEM_BYTES);
    end

    assign accept = req_valid & ~flush & ~bad_req;
    assign ld_now = accept & ~req_we;

    assign mem_we         = accept & req_we & ~rst;
    assign mem_data_width = req_funct3[1:0];
    assign mem_addr       = req_addr[ADDR_W-1:0];
    assign mem_wdata      = req_wdata;

    always_comb begin
        fault_d = req_valid & ~flush & bad_req;
        faddr_d = fault_d ? req_addr : faddr_q;
        s1_d = '{valid: ld_now, rd: req_rd,
                 width: req_funct3[1:0], uns: req_funct3[2]};
        s2_d = s1_q;
        if (flush) begin
            s1_d.valid = 1'b0;
            s2_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            fault_q <= 1'b0;
            faddr_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            fault_q <= fault_d;
            faddr_q <= faddr_d;
        end
    end

    load_extend u_ext (
        .width_i  (s2_q.width),
        .uns_i    (s2_q.uns),
        .rdata_i  (mem_rdata),
        .result_o (ext_data)
    );

    assign wb_valid    = s2_q.valid & (s2_q.rd != 4'd0) & ~flush;
    assign wb_rd       = s2_q.rd;
    assign wb_data     = wb_valid ? ext_data : 32'd0;
    assign fault_valid = fault_q;
    assign fault_addr  = faddr_q;

    // Stage2 is left out: its result is forwarded from writeback.
    function automatic logic hit(input logic [3:0] rs);
        return (rs != 4'd0)
             & ((ld_now & (rs == req_rd))
              | (s1_q.valid & (rs == s1_q.rd)));
    endfunction

    assign load_use_hazard = hit(id_rs1) | hit(id_rs2);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed
// 2-cycle-latency memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int DEPTH = 4096;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_rd;
    logic        flush;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        mem_we;
    logic [1:0]  mem_data_width;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault_valid;
    logic [31:0] fault_addr;
    logic        load_use_hazard;

    int checks = 0;
    int passes = 0;

    load_store_unit #(.DATA_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .flush           (flush),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .mem_we          (mem_we),
        .mem_data_width  (mem_data_width),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .wb_valid        (wb_valid),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .fault_valid     (fault_valid),
        .fault_addr      (fault_addr),
        .load_use_hazard (load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:NBYTES-1];
    logic [31:0] rpipe;

    function automatic logic [31:0] rd_word(input logic [13:0] a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = mem[(int'(a) + b) % NBYTES];
        return w;
    endfunction

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (b < ((mem_data_width == 2'b00) ? 1 :
                         (mem_data_width == 2'b01) ? 2 : 4))
                    mem[(int'(mem_addr) + b) % NBYTES]
                        <= mem_wdata[8*b +: 8];
            end
        end
        rpipe     <= rd_word(mem_addr);
        mem_rdata <= rpipe;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h",
                      name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic req(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] rd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_rd     = rd;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        flush     = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  rd;
        logic        e_we;
        logic        e_fault;
        logic        e_wb;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [17];

    initial begin
        vecs[0]  = '{1, FUNCT3_SW,  32'h10, 32'hDEADBEEF, 0,
                     1, 0, 0, 32'h0};
        vecs[1]  = '{0, FUNCT3_LW,  32'h10, 32'h0, 5,
                     0, 0, 1, 32'hDEADBEEF};
        vecs[2]  = '{0, FUNCT3_LB,  32'h13, 32'h0, 6,
                     0, 0, 1, 32'hFFFFFFDE};
        vecs[3]  = '{0, FUNCT3_LBU, 32'h13, 32'h0, 7,
                     0, 0, 1, 32'h000000DE};
        vecs[4]  = '{0, FUNCT3_LH,  32'h11, 32'h0, 8,
                     0, 0, 1, 32'hFFFFADBE};
        vecs[5]  = '{0, FUNCT3_LHU, 32'h12, 32'h0, 9,
                     0, 0, 1, 32'h0000DEAD};
        vecs[6]  = '{0, FUNCT3_LW,  32'h3FFE, 32'h0, 1,
                     0, 1, 0, 32'h0};
        vecs[7]  = '{1, 3'b100,     32'h20, 32'h55, 0,
                     0, 1, 0, 32'h0};
        vecs[8]  = '{0, 3'b011,     32'h40, 32'h0, 2,
                     0, 1, 0, 32'h0};
        vecs[9]  = '{0, FUNCT3_LW,  32'h00010000, 32'h0, 3,
                     0, 1, 0, 32'h0};
        vecs[10] = '{1, FUNCT3_SB,  32'h3FFF, 32'h00000080, 0,
                     1, 0, 0, 32'h0};
        vecs[11] = '{0, FUNCT3_LB,  32'h3FFF, 32'h0, 4,
                     0, 0, 1, 32'hFFFFFF80};
        vecs[12] = '{1, FUNCT3_SH,  32'h20, 32'h1234ABCD, 0,
                     1, 0, 0, 32'h0};
        vecs[13] = '{0, FUNCT3_LH,  32'h20, 32'h0, 10,
                     0, 0, 1, 32'hFFFFABCD};
        vecs[14] = '{0, FUNCT3_LW,  32'h10, 32'h0, 0,
                     0, 0, 0, 32'h0};
        vecs[15] = '{1, FUNCT3_SW,  32'h3FFC, 32'h11223344, 0,
                     1, 0, 0, 32'h0};
        vecs[16] = '{0, FUNCT3_LW,  32'h3FFC, 32'h0, 11,
                     0, 0, 1, 32'h11223344};

        rst = 1'b1;
        idle();
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 4'd0;
        id_rs1     = 4'd0;
        id_rs2     = 4'd0;
        #3;
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_rd", 32'(wb_rd), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst fault_valid", 32'(fault_valid), 32'd0);
        chk("rst fault_addr", fault_addr, 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        #9 rst = 1'b0;
        step();

        for (int i = 0; i < 17; i++) begin
            req(vecs[i].we, vecs[i].f3, vecs[i].addr,
                vecs[i].wdata, vecs[i].rd);
            settle();
            chk($sformatf("v%0d mem_we", i),
                32'(mem_we), 32'(vecs[i].e_we));
            step();
            idle();
            settle();
            chk($sformatf("v%0d fault_valid", i),
                32'(fault_valid), 32'(vecs[i].e_fault));
            if (vecs[i].e_fault)
                chk($sformatf("v%0d fault_addr", i),
                    fault_addr, vecs[i].addr);
            step();
            settle();
            chk($sformatf("v%0d wb_valid", i),
                32'(wb_valid), 32'(vecs[i].e_wb));
            chk($sformatf("v%0d wb_data", i),
                wb_data, vecs[i].e_data);
            if (vecs[i].e_wb)
                chk($sformatf("v%0d wb_rd", i),
                    32'(wb_rd), 32'(vecs[i].rd));
            step();
        end

        // store followed immediately by a load of the same word
        req(1, FUNCT3_SW, 32'h30, 32'hCAFEF00D, 0);
        settle();
        chk("sl mem_we", 32'(mem_we), 32'd1);
        step();
        req(0, FUNCT3_LW, 32'h30, 32'h0, 5);
        step();
        idle();
        settle();
        chk("sl early wb", 32'(wb_valid), 32'd0);
        step();
        settle();
        chk("sl wb_valid", 32'(wb_valid), 32'd1);
        chk("sl wb_rd", 32'(wb_rd), 32'd5);
        chk("sl wb_data", wb_data, 32'hCAFEF00D);
        step();

        // streaming x1,x2,x3
        req(0, FUNCT3_LW, 32'h10, 32'h0, 1);
        step();
        req(0, FUNCT3_LH, 32'h20, 32'h0, 2);
        step();
        req(0, FUNCT3_LBU, 32'h11, 32'h0, 3);
        settle();
        chk("st1 wb_valid", 32'(wb_valid), 32'd1);
        chk("st1 wb_rd", 32'(wb_rd), 32'd1);
        chk("st1 wb_data", wb_data, 32'hDEADBEEF);
        step();
        idle();
        settle();
        chk("st2 wb_valid", 32'(wb_valid), 32'd1);
        chk("st2 wb_rd", 32'(wb_rd), 32'd2);
        chk("st2 wb_data", wb_data, 32'hFFFFABCD);
        step();
        settle();
        chk("st3 wb_valid", 32'(wb_valid), 32'd1);
        chk("st3 wb_rd", 32'(wb_rd), 32'd3);
        chk("st3 wb_data", wb_data, 32'h000000BE);
        step();

        // streaming x1,x0,x3
        req(0, FUNCT3_LW, 32'h10, 32'h0, 1);
        step();
        req(0, FUNCT3_LW, 32'h10, 32'h0, 0);
        step();
        req(0, FUNCT3_LW, 32'h30, 32'h0, 3);
        settle();
        chk("sz1 wb_valid", 32'(wb_valid), 32'd1);
        step();
        idle();
        settle();
        chk("sz0 wb_valid", 32'(wb_valid), 32'd0);
        step();
        settle();
        chk("sz3 wb_valid", 32'(wb_valid), 32'd1);
        chk("sz3 wb_data", wb_data, 32'hCAFEF00D);
        step();

        // flush one cycle after a load, with a store in the flush cycle
        req(0, FUNCT3_LW, 32'h10, 32'h0, 4);
        step();
        req(1, FUNCT3_SW, 32'h30, 32'h12345678, 0);
        flush = 1'b1;
        settle();
        chk("fl store mem_we", 32'(mem_we), 32'd0);
        step();
        idle();
        settle();
        chk("fl wb_valid", 32'(wb_valid), 32'd0);
        step();
        req(0, FUNCT3_LW, 32'h30, 32'h0, 5);
        step();
        idle();
        step();
        settle();
        chk("fl store dropped", wb_data, 32'hCAFEF00D);
        step();

        // flush in the writeback cycle and on a faulting request
        req(0, FUNCT3_LW, 32'h10, 32'h0, 6);
        step();
        idle();
        step();
        req(0, FUNCT3_LW, 32'h3FFE, 32'h0, 7);
        flush = 1'b1;
        settle();
        chk("flw wb_valid", 32'(wb_valid), 32'd0);
        step();
        idle();
        settle();
        chk("flf fault_valid", 32'(fault_valid), 32'd0);
        step();

        // asynchronous reset with two loads in flight
        req(0, FUNCT3_LW, 32'h10, 32'h0, 1);
        step();
        req(0, FUNCT3_LW, 32'h10, 32'h0, 2);
        step();
        req(1, FUNCT3_SW, 32'h30, 32'h0BADF00D, 0);
        settle();
        chk("rm wb before", 32'(wb_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rm wb_valid", 32'(wb_valid), 32'd0);
        chk("rm wb_data", wb_data, 32'd0);
        chk("rm mem_we", 32'(mem_we), 32'd0);
        step();
        idle();
        #2 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            settle();
            chk($sformatf("rm late wb %0d", c),
                32'(wb_valid), 32'd0);
        end
        step();
        req(0, FUNCT3_LW, 32'h30, 32'h0, 5);
        step();
        idle();
        step();
        settle();
        chk("rm no store", wb_data, 32'hCAFEF00D);
        step();

        // load-use hazard
        id_rs1 = 4'd5;
        req(0, FUNCT3_LW, 32'h10, 32'h0, 5);
        settle();
        chk("hz N", 32'(load_use_hazard), 32'd1);
        step();
        idle();
        settle();
        chk("hz N+1", 32'(load_use_hazard), 32'd1);
        step();
        settle();
        chk("hz N+2", 32'(load_use_hazard), 32'd0);
        step();
        id_rs1 = 4'd0;
        id_rs2 = 4'd0;
        req(0, FUNCT3_LW, 32'h10, 32'h0, 0);
        settle();
        chk("hz x0 N", 32'(load_use_hazard), 32'd0);
        step();
        idle();
        settle();
        chk("hz x0 N+1", 32'(load_use_hazard), 32'd0);
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
